// File: rtl/dstack_unit.sv
// rtl/dstack_unit.sv - register-file data stack with push/pop/replace, copy and multi-cycle rotate
module dstack_unit #(
    parameter int WORD_WIDTH = 32,
    parameter int DEPTH      = 32,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  op_valid,
    output logic                  op_ready,
    input  logic [1:0]            movement,
    input  logic                  rotate,
    input  logic                  copy,
    input  logic [AW-1:0]         rotate_addr,
    input  logic [WORD_WIDTH-1:0] next_top,
    output logic [WORD_WIDTH-1:0] top,
    output logic [WORD_WIDTH-1:0] second,
    output logic [WORD_WIDTH-1:0] third,
    output logic [AW:0]           depth,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  clear_err
);

    localparam logic [AW:0]   DEPTH_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   D_ONE      = (AW+1)'(1);
    localparam logic [AW:0]   D_TWO      = (AW+1)'(2);
    localparam logic [AW:0]   D_THREE    = (AW+1)'(3);
    localparam logic [AW-1:0] C_ONE      = AW'(1);

    typedef enum logic {IDLE, ROT} state_t;

    state_t                  state_q, state_d;
    logic [WORD_WIDTH-1:0]   mem_q [DEPTH];
    logic [WORD_WIDTH-1:0]   mem_d [DEPTH];
    logic [AW:0]             depth_q, depth_d;
    logic [AW-1:0]           cnt_q, cnt_d;
    logic                    ovf_q, ovf_d;
    logic                    unf_q, unf_d;

    logic                    accept;
    logic                    k_valid;
    logic                    push_en;
    logic [WORD_WIDTH-1:0]   push_val;

    assign accept  = op_valid && (state_q == IDLE);
    assign k_valid = ({1'b0, rotate_addr} < depth_q);

    // Next-state: decode the accepted operation, or step one rotate swap while in ROT
    always_comb begin
        state_d  = state_q;
        mem_d    = mem_q;
        depth_d  = depth_q;
        cnt_d    = cnt_q;
        ovf_d    = clear_err ? 1'b0 : ovf_q;
        unf_d    = clear_err ? 1'b0 : unf_q;
        push_en  = 1'b0;
        push_val = '0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (copy && !rotate) begin
                        push_en  = 1'b1;
                        push_val = k_valid ? mem_q[rotate_addr] : '0;
                        if (!k_valid) unf_d = 1'b1;
                    end else if (rotate && !copy) begin
                        if (rotate_addr != '0) begin
                            if (!k_valid) begin
                                unf_d = 1'b1;
                            end else begin
                                cnt_d   = rotate_addr;
                                state_d = ROT;
                            end
                        end
                    end else if (!rotate && !copy) begin
                        case (movement)
                            2'b00: begin
                                if (depth_q == '0) unf_d = 1'b1;
                                else mem_d[0] = next_top;
                            end
                            2'b01: begin
                                push_en  = 1'b1;
                                push_val = next_top;
                            end
                            2'b10: begin
                                mem_d[0] = next_top;
                                if (depth_q < D_TWO) begin
                                    unf_d   = 1'b1;
                                    depth_d = D_ONE;
                                end else begin
                                    for (int i = 1; i < DEPTH - 1; i++) mem_d[i] = mem_q[i+1];
                                    mem_d[DEPTH-1] = '0;
                                    depth_d = depth_q - D_ONE;
                                end
                            end
                            default: begin
                                mem_d[0] = next_top;
                                if (depth_q < D_THREE) begin
                                    unf_d   = 1'b1;
                                    depth_d = D_ONE;
                                end else begin
                                    for (int i = 1; i < DEPTH - 2; i++) mem_d[i] = mem_q[i+2];
                                    mem_d[DEPTH-2] = '0;
                                    mem_d[DEPTH-1] = '0;
                                    depth_d = depth_q - D_TWO;
                                end
                            end
                        endcase
                    end
                end
            end
            default: begin
                mem_d[cnt_q - C_ONE] = mem_q[cnt_q];
                mem_d[cnt_q]         = mem_q[cnt_q - C_ONE];
                cnt_d                = cnt_q - C_ONE;
                if (cnt_q == C_ONE) state_d = IDLE;
            end
        endcase

        // Push and copy share the shift-down path; a full stack drops its bottom entry
        if (push_en) begin
            for (int i = DEPTH - 1; i > 0; i--) mem_d[i] = mem_q[i-1];
            mem_d[0] = push_val;
            if (depth_q == DEPTH_FULL) ovf_d = 1'b1;
            else depth_d = depth_q + D_ONE;
        end
    end

    // State registers; reset clears storage so an aborted rotate leaves nothing behind
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            depth_q <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q <= state_d;
            depth_q <= depth_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
        end
    end

    assign op_ready  = (state_q == IDLE);
    assign top       = mem_q[0];
    assign second    = mem_q[1];
    assign third     = mem_q[2];
    assign depth     = depth_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

endmodule

// File: tb/tb_dstack_unit.sv
// tb/tb_dstack_unit.sv - directed self-checking bench for dstack_unit
module tb_dstack_unit;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;

    logic        op_valid = 1'b0, rotate = 1'b0, copy = 1'b0, clear_err = 1'b0;
    logic [1:0]  movement = 2'b00;
    logic [2:0]  rotate_addr = '0;
    logic [15:0] next_top = '0;
    logic        op_ready, overflow, underflow;
    logic [15:0] top, second, third;
    logic [3:0]  depth;

    logic        op_valid4 = 1'b0, clear_err4 = 1'b0;
    logic [1:0]  movement4 = 2'b00;
    logic [1:0]  rotate_addr4 = '0;
    logic [15:0] next_top4 = '0;
    logic        op_ready4, overflow4, underflow4;
    logic [15:0] top4, second4, third4;
    logic [2:0]  depth4;

    int vectors = 0;
    int miscompares = 0;
    int n;

    dstack_unit #(.WORD_WIDTH(16), .DEPTH(8)) u_dut (
        .clk(clk), .reset_n(reset_n), .op_valid(op_valid), .op_ready(op_ready),
        .movement(movement), .rotate(rotate), .copy(copy), .rotate_addr(rotate_addr),
        .next_top(next_top), .top(top), .second(second), .third(third), .depth(depth),
        .overflow(overflow), .underflow(underflow), .clear_err(clear_err)
    );

    dstack_unit #(.WORD_WIDTH(16), .DEPTH(4)) u_dut4 (
        .clk(clk), .reset_n(reset_n), .op_valid(op_valid4), .op_ready(op_ready4),
        .movement(movement4), .rotate(1'b0), .copy(1'b0), .rotate_addr(rotate_addr4),
        .next_top(next_top4), .top(top4), .second(second4), .third(third4), .depth(depth4),
        .overflow(overflow4), .underflow(underflow4), .clear_err(clear_err4)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_op(input logic [1:0] mv, input logic rot, input logic cp,
                         input logic [2:0] k, input logic [15:0] val, input logic clr);
        @(negedge clk);
        op_valid = 1'b1; movement = mv; rotate = rot; copy = cp;
        rotate_addr = k; next_top = val; clear_err = clr;
        @(negedge clk);
        op_valid = 1'b0; rotate = 1'b0; copy = 1'b0; clear_err = 1'b0;
    endtask

    task automatic do_op4(input logic [1:0] mv, input logic [15:0] val, input logic vld,
                          input logic clr);
        @(negedge clk);
        op_valid4 = vld; movement4 = mv; next_top4 = val; clear_err4 = clr;
        @(negedge clk);
        op_valid4 = 1'b0; clear_err4 = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic push4321();
        for (int i = 1; i <= 4; i++) do_op(2'b01, 1'b0, 1'b0, 3'd0, 16'(i), 1'b0);
    endtask

    initial begin
        #12;
        chk("rst_top", top, 0);
        chk("rst_second", second, 0);
        chk("rst_third", third, 0);
        chk("rst_depth", depth, 0);
        chk("rst_flags", {overflow, underflow}, 0);
        chk("rst_ready", op_ready, 1);
        @(negedge clk);
        reset_n = 1'b1;

        push4321();
        chk("push_top", top, 4);
        chk("push_second", second, 3);
        chk("push_third", third, 2);
        chk("push_depth", depth, 4);
        chk("push_flags", {overflow, underflow}, 0);

        op_valid = 1'b0;
        do_op4(2'b01, 16'h0, 1'b0, 1'b0);
        chk("idle_no_change", {top, depth}, {16'd4, 4'd4});

        do_op(2'b00, 1'b0, 1'b0, 3'd0, 16'h77, 1'b0);
        chk("replace_top", {top, second}, {16'h77, 16'd3});
        chk("replace_depth", depth, 4);
        do_op(2'b00, 1'b0, 1'b0, 3'd0, 16'd4, 1'b0);

        do_op(2'b01, 1'b1, 1'b1, 3'd1, 16'hAA, 1'b0);
        chk("both_set_noop", {top, depth}, {16'd4, 4'd4});

        do_op(2'b00, 1'b0, 1'b1, 3'd2, 16'hAA, 1'b0);
        chk("copy_top", top, 2);
        chk("copy_second", second, 4);
        chk("copy_depth", depth, 5);
        do_op(2'b00, 1'b0, 1'b1, 3'd7, 16'hAA, 1'b0);
        chk("copy_bad_unf", underflow, 1);
        chk("copy_bad_top", top, 0);
        chk("copy_bad_depth", depth, 6);
        @(negedge clk);
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
        chk("clear_unf", underflow, 0);

        do_reset();
        push4321();
        do_op(2'b00, 1'b1, 1'b0, 3'd3, 16'h0, 1'b0);
        n = 0;
        while (!op_ready && n < 10) begin
            n++;
            @(negedge clk);
        end
        chk("rot_busy_cycles", n, 3);
        chk("rot_top", top, 1);
        chk("rot_second", second, 4);
        chk("rot_third", third, 3);
        chk("rot_depth", depth, 4);

        do_op(2'b00, 1'b1, 1'b0, 3'd0, 16'h0, 1'b0);
        chk("rot0_ready", op_ready, 1);
        chk("rot0_top", {top, second}, {16'd1, 16'd4});
        do_op(2'b00, 1'b1, 1'b0, 3'd5, 16'h0, 1'b0);
        chk("rot_bad_unf", underflow, 1);
        chk("rot_bad_ready", op_ready, 1);
        chk("rot_bad_top", top, 1);

        do_reset();
        do_op(2'b10, 1'b0, 1'b0, 3'd0, 16'h55, 1'b1);
        chk("clr_vs_set_unf", underflow, 1);
        chk("pop_empty_state", {top, depth}, {16'h55, 4'd1});

        do_reset();
        push4321();
        do_op(2'b11, 1'b0, 1'b0, 3'd0, 16'd9, 1'b0);
        chk("pop2_top", top, 9);
        chk("pop2_second", second, 1);
        chk("pop2_depth", depth, 2);
        do_op(2'b10, 1'b0, 1'b0, 3'd0, 16'd8, 1'b0);
        chk("pop1_state", {top, depth, underflow}, {16'd8, 4'd1, 1'b0});
        do_op(2'b10, 1'b0, 1'b0, 3'd0, 16'd6, 1'b0);
        chk("pop1_unf", underflow, 1);
        chk("pop1_unf_depth", {top, depth}, {16'd6, 4'd1});

        do_reset();
        push4321();
        do_op(2'b00, 1'b1, 1'b0, 3'd3, 16'h0, 1'b0);
        chk("midrot_busy", op_ready, 0);
        #2 reset_n = 1'b0;
        #1;
        chk("midrot_rst_depth", depth, 0);
        chk("midrot_rst_outs", {top, second, third}, 48'h0);
        chk("midrot_rst_ready", op_ready, 1);
        @(negedge clk);
        reset_n = 1'b1;
        do_op(2'b01, 1'b0, 1'b0, 3'd0, 16'h5, 1'b0);
        chk("resume_push", {top, second, depth}, {16'd5, 16'd0, 4'd1});

        for (int i = 1; i <= 5; i++) do_op4(2'b01, 16'(i), 1'b1, 1'b0);
        chk("ovf_flag", overflow4, 1);
        chk("ovf_depth", depth4, 4);
        chk("ovf_top", {top4, second4}, {16'd5, 16'd4});
        do_op4(2'b00, 16'h0, 1'b0, 1'b1);
        chk("ovf_clear", overflow4, 0);
        do_op4(2'b11, 16'hE, 1'b1, 1'b0);
        chk("ovf_bottom", {top4, second4, depth4}, {16'hE, 16'd2, 3'd2});

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
